// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU operation encoding and RV32I opcode constants for the ALU issue stage.
// The ALU add path subtracts when bit0 is set, so SUB/SLT/SLTU are odd and ADD is even.
package alu_issue_stage_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_PASS = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1100;
   localparam logic [3:0] ALU_SLL  = 4'b1110;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   function automatic logic is_shift(input logic [2:0] funct3);
      return funct3[1:0] == 2'b01;
   endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into ALUOp and operand selection.
// Shift amounts are masked here because the ALU shifts by the full SrcB.
module alu_op_decode
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [6:0]      opcode_i,
   input  logic [2:0]      funct3_i,
   input  logic            funct7b5_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [3:0]      alu_op_o,
   output logic [XLEN-1:0] src_a_o,
   output logic [XLEN-1:0] src_b_o,
   output logic            illegal_o
);

   logic            is_op;
   logic [XLEN-1:0] operand_b;

   assign is_op     = (opcode_i == OPC_OP);
   assign operand_b = is_op ? rs2_data_i : imm_i;

   always_comb begin
      alu_op_o  = ALU_PASS;
      src_a_o   = '0;
      src_b_o   = '0;
      illegal_o = 1'b0;
      unique case (opcode_i)
         OPC_OP, OPC_OPIMM: begin
            src_a_o = rs1_data_i;
            src_b_o = is_shift(funct3_i) ? {{(XLEN-5){1'b0}}, operand_b[4:0]} : operand_b;
            unique case (funct3_i)
               3'b000:  alu_op_o = (is_op && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op_o = ALU_SLL;
               3'b010:  alu_op_o = ALU_SLT;
               3'b011:  alu_op_o = ALU_SLTU;
               3'b100:  alu_op_o = ALU_XOR;
               3'b101:  alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op_o = ALU_OR;
               default: alu_op_o = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            src_b_o = imm_i;
         end
         OPC_AUIPC: begin
            alu_op_o = ALU_ADD;
            src_a_o  = pc_i;
            src_b_o  = imm_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes an instruction and holds it in a 2-entry skid buffer.
// InReady is a pure register output so OutReady never reaches upstream combinationally.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [6:0]       Opcode,
   input  logic [2:0]       Funct3,
   input  logic             Funct7b5,
   input  logic [XLEN-1:0]  Rs1Data,
   input  logic [XLEN-1:0]  Rs2Data,
   input  logic [XLEN-1:0]  Imm,
   input  logic [XLEN-1:0]  PC,
   input  logic [TAG_W-1:0] TagIn,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [XLEN-1:0]  SrcA,
   output logic [XLEN-1:0]  SrcB,
   output logic [3:0]       ALUOp,
   output logic [TAG_W-1:0] TagOut,
   output logic             IllegalOut
);

   // Entry layout: {illegal, tag, alu_op, src_b, src_a}
   localparam int unsigned EntW = 2 * XLEN + 4 + TAG_W + 1;
   localparam logic [EntW-1:0] ResetEnt = {1'b0, {TAG_W{1'b0}}, ALU_ADD, {(2 * XLEN){1'b0}}};

   logic [3:0]      dec_op;
   logic [XLEN-1:0] dec_src_a;
   logic [XLEN-1:0] dec_src_b;
   logic            dec_illegal;

   logic [EntW-1:0] new_ent;
   logic [EntW-1:0] main_q, main_d;
   logic [EntW-1:0] skid_q, skid_d;
   logic            main_valid_q, main_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic            accept;
   logic            xfer;

   alu_op_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .opcode_i   (Opcode),
      .funct3_i   (Funct3),
      .funct7b5_i (Funct7b5),
      .rs1_data_i (Rs1Data),
      .rs2_data_i (Rs2Data),
      .imm_i      (Imm),
      .pc_i       (PC),
      .alu_op_o   (dec_op),
      .src_a_o    (dec_src_a),
      .src_b_o    (dec_src_b),
      .illegal_o  (dec_illegal)
   );

   assign new_ent = {dec_illegal, TagIn, dec_op, dec_src_b, dec_src_a};
   assign accept  = InValid && !skid_valid_q;
   assign xfer    = main_valid_q && OutReady;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (Flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || xfer) begin
         // Main slot frees up: the older skid entry has priority over a new accept.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d       = new_ent;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = new_ent;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= ResetEnt;
         skid_q       <= ResetEnt;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign {IllegalOut, TagOut, ALUOp, SrcB, SrcA} = main_q;
   assign OutValid = main_valid_q;
   assign InReady  = !skid_valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   logic        clk, rst_n, Flush, InValid, InReady, OutValid, OutReady, Funct7b5, IllegalOut;
   logic [6:0]  Opcode;
   logic [2:0]  Funct3;
   logic [31:0] Rs1Data, Rs2Data, Imm, PC, SrcA, SrcB;
   logic [3:0]  ALUOp;
   logic [4:0]  TagIn, TagOut;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  tag;
      logic        ill;
      logic        subk;
      logic        addk;
   } exp_t;

   exp_t q[$];

   alu_issue_stage #(
      .XLEN  (32),
      .TAG_W (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Flush      (Flush),
      .InValid    (InValid),
      .InReady    (InReady),
      .Opcode     (Opcode),
      .Funct3     (Funct3),
      .Funct7b5   (Funct7b5),
      .Rs1Data    (Rs1Data),
      .Rs2Data    (Rs2Data),
      .Imm        (Imm),
      .PC         (PC),
      .TagIn      (TagIn),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUOp      (ALUOp),
      .TagOut     (TagOut),
      .IllegalOut (IllegalOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference ALU, used only to pin operand/opcode pairs to their architectural result.
   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, b);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b;
         ALU_SRL:  return a >> b;
         ALU_SRA:  return 32'($signed(a) >>> b);
         ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'b0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return b;
      endcase
   endfunction

   function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] rs1, rs2, imm, pc, input logic [4:0] tag);
      exp_t e;
      logic [31:0] opnd;
      e     = '0;
      e.tag = tag;
      e.op  = ALU_PASS;
      if (opc == OPC_OP || opc == OPC_OPIMM) begin
         e.a  = rs1;
         opnd = (opc == OPC_OP) ? rs2 : imm;
         e.b  = opnd;
         case (f3)
            3'd0: if (opc == OPC_OP && f7) begin e.op = ALU_SUB; e.subk = 1'b1; end
                  else begin e.op = ALU_ADD; e.addk = 1'b1; end
            3'd1: begin e.op = ALU_SLL; e.b = opnd % 32; end
            3'd2: begin e.op = ALU_SLT; e.subk = 1'b1; end
            3'd3: begin e.op = ALU_SLTU; e.subk = 1'b1; end
            3'd4: e.op = ALU_XOR;
            3'd5: begin e.op = f7 ? ALU_SRA : ALU_SRL; e.b = opnd % 32; end
            3'd6: e.op = ALU_OR;
            default: e.op = ALU_AND;
         endcase
      end else if (opc == OPC_LUI) begin
         e.b = imm;
      end else if (opc == OPC_AUIPC) begin
         e.op   = ALU_ADD;
         e.addk = 1'b1;
         e.a    = pc;
         e.b    = imm;
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   // Model: a FIFO of at most two decoded entries.
   int  m_n;
   bit  m_acc, m_xfer;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         m_n    = q.size();
         m_acc  = InValid && (m_n < 2);
         m_xfer = (m_n > 0) && OutReady;
         if (Flush) begin
            q.delete();
         end else begin
            if (m_xfer) void'(q.pop_front());
            if (m_acc) q.push_back(model(Opcode, Funct3, Funct7b5, Rs1Data, Rs2Data, Imm, PC,
                                         TagIn));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", {31'b0, InReady}, {31'b0, q.size() < 2});
         check("out_valid", {31'b0, OutValid}, {31'b0, q.size() > 0});
         if (q.size() > 0 && OutValid) begin
            check("src_a", SrcA, q[0].a);
            check("src_b", SrcB, q[0].b);
            check("alu_op", {28'b0, ALUOp}, {28'b0, q[0].op});
            check("tag_out", {27'b0, TagOut}, {27'b0, q[0].tag});
            check("illegal", {31'b0, IllegalOut}, {31'b0, q[0].ill});
            if (q[0].subk) check("aluop_bit0_sub", {31'b0, ALUOp[0]}, 32'd1);
            if (q[0].addk) check("aluop_bit0_add", {31'b0, ALUOp[0]}, 32'd0);
         end
      end
   end

   task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, rs2, imm, pc, input logic [4:0] tag);
      InValid  = 1'b1;
      Opcode   = opc;
      Funct3   = f3;
      Funct7b5 = f7;
      Rs1Data  = rs1;
      Rs2Data  = rs2;
      Imm      = imm;
      PC       = pc;
      TagIn    = tag;
   endtask

   initial begin
      rst_n = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
      send(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      InValid = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", {31'b0, OutValid}, 32'd0);
      check("rst_in_ready", {31'b0, InReady}, 32'd1);
      check("rst_src_a", SrcA, 32'd0);
      check("rst_src_b", SrcB, 32'd0);
      check("rst_alu_op", {28'b0, ALUOp}, {28'b0, ALU_ADD});
      check("rst_tag", {27'b0, TagOut}, 32'd0);
      check("rst_illegal", {31'b0, IllegalOut}, 32'd0);
      @(negedge clk); rst_n = 1'b1; OutReady = 1'b1;

      // SUB
      @(negedge clk); send(OPC_OP, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd1);
      @(negedge clk); InValid = 1'b0;
      check("sub_valid", {31'b0, OutValid}, 32'd1);
      check("sub_op", {28'b0, ALUOp}, {28'b0, ALU_SUB});
      check("sub_a", SrcA, 32'd10);
      check("sub_b", SrcB, 32'd3);
      check("sub_result", alu(ALUOp, SrcA, SrcB), 32'd7);
      // SRAI with imm bits above [4:0] set
      send(OPC_OPIMM, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0423, 32'd0, 5'd2);
      @(negedge clk); InValid = 1'b0;
      check("srai_op", {28'b0, ALUOp}, {28'b0, ALU_SRA});
      check("srai_b", SrcB, 32'd3);
      check("srai_result", alu(ALUOp, SrcA, SrcB), 32'hF000_0000);
      // SLL masked register shift amount
      send(OPC_OP, 3'd1, 1'b0, 32'd5, 32'h0000_0021, 32'd0, 32'd0, 5'd3);
      @(negedge clk); InValid = 1'b0;
      check("sll_op", {28'b0, ALUOp}, {28'b0, ALU_SLL});
      check("sll_b", SrcB, 32'd1);
      // LUI
      send(OPC_LUI, 3'd0, 1'b0, 32'hDEAD, 32'd0, 32'h1234_5000, 32'd0, 5'd4);
      @(negedge clk); InValid = 1'b0;
      check("lui_op", {28'b0, ALUOp}, {28'b0, ALU_PASS});
      check("lui_a", SrcA, 32'd0);
      check("lui_b", SrcB, 32'h1234_5000);
      // AUIPC
      send(OPC_AUIPC, 3'd0, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h100, 5'd5);
      @(negedge clk); InValid = 1'b0;
      check("auipc_op", {28'b0, ALUOp}, {28'b0, ALU_ADD});
      check("auipc_a", SrcA, 32'h100);
      check("auipc_result", alu(ALUOp, SrcA, SrcB), 32'h2100);
      // Unsupported opcode (branch)
      send(7'b1100011, 3'd0, 1'b0, 32'd7, 32'd9, 32'd11, 32'd0, 5'd6);
      @(negedge clk); InValid = 1'b0;
      check("ill_flag", {31'b0, IllegalOut}, 32'd1);
      check("ill_op", {28'b0, ALUOp}, {28'b0, ALU_PASS});
      check("ill_b", SrcB, 32'd0);
      @(negedge clk);

      // Back-pressure: third instruction must be refused, then all drain in order.
      OutReady = 1'b0;
      send(OPC_OP, 3'd4, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd11);
      @(negedge clk); check("bp_ready1", {31'b0, InReady}, 32'd1);
      send(OPC_OP, 3'd6, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 5'd12);
      @(negedge clk); check("bp_ready2", {31'b0, InReady}, 32'd0);
      send(OPC_OP, 3'd7, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 5'd13);
      @(negedge clk); InValid = 1'b0;
      check("bp_ready3", {31'b0, InReady}, 32'd0);
      check("bp_hold_tag", {27'b0, TagOut}, 32'd11);
      check("bp_hold_a", SrcA, 32'd1);
      OutReady = 1'b1;
      @(negedge clk);
      check("bp_second_tag", {27'b0, TagOut}, 32'd12);
      check("bp_ready_back", {31'b0, InReady}, 32'd1);
      @(negedge clk);
      check("bp_drained", {31'b0, OutValid}, 32'd0);

      // Flush with both entries full and a pending instruction.
      OutReady = 1'b0;
      send(OPC_OP, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd21);
      @(negedge clk); send(OPC_OP, 3'd0, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 5'd22);
      @(negedge clk); send(OPC_OP, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 5'd23);
      Flush = 1'b1;
      @(negedge clk); Flush = 1'b0; InValid = 1'b0;
      check("flush_valid", {31'b0, OutValid}, 32'd0);
      check("flush_ready", {31'b0, InReady}, 32'd1);
      // Flush beats an accept into an empty stage.
      send(OPC_OP, 3'd0, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 5'd24);
      Flush = 1'b1;
      @(negedge clk); Flush = 1'b0; InValid = 1'b0;
      check("flush_drop", {31'b0, OutValid}, 32'd0);

      // Asynchronous reset mid-stream.
      send(OPC_OP, 3'd2, 1'b0, 32'd8, 32'd9, 32'd0, 32'd0, 5'd25);
      @(negedge clk); send(OPC_OP, 3'd3, 1'b0, 32'd8, 32'd9, 32'd0, 32'd0, 5'd26);
      @(negedge clk); InValid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, OutValid}, 32'd0);
      check("arst_ready", {31'b0, InReady}, 32'd1);
      check("arst_tag", {27'b0, TagOut}, 32'd0);
      check("arst_op", {28'b0, ALUOp}, {28'b0, ALU_ADD});
      @(negedge clk); rst_n = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 5))
            0, 5:    Opcode = OPC_OP;
            1:       Opcode = OPC_OPIMM;
            2:       Opcode = OPC_LUI;
            3:       Opcode = OPC_AUIPC;
            default: Opcode = 7'($urandom);
         endcase
         InValid  = ($urandom_range(0, 3) != 0);
         OutReady = ($urandom_range(0, 2) != 0);
         Flush    = ($urandom_range(0, 31) == 0);
         Funct3   = 3'($urandom);
         Funct7b5 = 1'($urandom);
         Rs1Data  = $urandom;
         Rs2Data  = $urandom;
         Imm      = $urandom;
         PC       = $urandom;
         TagIn    = 5'($urandom);
      end
      @(negedge clk);
      InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
